param_streamer: RTL and testbench
=================================

# param_streamer

Parameter source for the neuron-array engine: buffers a whole network's weights and biases loaded by the host, then replays them word by word as the engine's control path raises `weight_en` / `bias_en`. Its `wt_data` / `bias_data` outputs drive the engine's `wt_in` / `bias_in`. Words are stored and replayed in consumption order; the host owns the ordering across layers and inputs. A stored set can be replayed for any number of inferences without reloading.

## Interface
- `DATA_W`, 16: parameter word width (Q-format shared with compute units).
- `WDEPTH`, 1024: weight buffer depth in words.
- `BDEPTH`, 256: bias buffer depth in words.
- `clk` input 1: single clock, all state on rising edge.
- `reset` input 1: asynchronous, active-high; forces every register and output to its reset value.
- `host_we` input 1: host write strobe, honoured only in IDLE.
- `host_sel` input 1: 0 = weight buffer, 1 = bias buffer.
- `host_data` input DATA_W: word appended at the selected write pointer.
- `load_done` input 1: host finished loading.
- `clear` input 1: discard contents, return to IDLE.
- `start` input 1: same pulse that starts the engine; rewinds read pointers.
- `weight_en` input 1: engine consumes one weight word this edge.
- `bias_en` input 1: engine consumes one bias word this edge.
- `wt_data` output DATA_W: current weight word. Reset 0.
- `bias_data` output DATA_W: current bias word. Reset 0.
- `wt_count` output clog2(WDEPTH)+1: weights loaded. Reset 0.
- `bias_count` output clog2(BDEPTH)+1: biases loaded. Reset 0.
- `host_ready` output 1: high only in IDLE. Reset 1.
- `stream_done` output 1: high in DONE. Reset 0.
- `overflow` output 1: sticky, a write hit a full buffer. Reset 0.
- `underrun` output 1: sticky, a word was consumed past its count. Reset 0.

## Operation
- States: IDLE, READY, STREAM, DONE. Reset goes to IDLE.
- IDLE:
  - `host_we` writes `host_data` at the selected count, then increments that count.
  - A write with the selected count already at depth is dropped and sets `overflow`.
  - `load_done` goes to READY if `wt_count` > 0; otherwise it is ignored.
- READY: `start` goes to STREAM with both read pointers 0.
- STREAM:
  - An edge with `weight_en` advances `wt_ptr`; an edge with `bias_en` advances `b_ptr`. The two are independent and may occur in the same cycle.
  - When `wt_ptr` == `wt_count` and `b_ptr` == `bias_count`, go to DONE.
- DONE:
  - `start` re-enters STREAM with both pointers rewound.
  - Consumption in DONE sets `underrun`.
- `clear` from any state:
  - Goes to IDLE and zeroes both counts, both pointers, both data outputs and both sticky flags.
  - Buffer contents need not be erased.
- Priority: `reset` > `clear` > `start` > consumption. `start` during STREAM restarts the stream (pointers to 0); any same-cycle enables are ignored.
- Underrun:
  - A consumption edge with the pointer already at its count holds the pointer and sets `underrun`.
  - The corresponding data output stays 0.
- `host_we` outside IDLE is ignored; no flag is set.
- Both buffers are single-write, single-read synchronous RAM, inferable as block RAM.

## Timing
- Prefetch rule: `wt_data` always equals `wmem[wt_ptr]`, or 0 when `wt_ptr` == `wt_count`, valid from the cycle after the edge that set `wt_ptr`. The same rule applies to `bias_data` / `b_ptr`.
- Edge accepting `start` (cycle t): `wt_data` = `wmem[0]` and `bias_data` = `bmem[0]` from cycle t+1. The engine may assert an enable in t+1.
- Consumption edge at pointer p: the engine samples word p at that edge; the output shows word p+1 (or 0) in the next cycle. This supports one word per cycle, back-to-back, with zero bubbles.
- Host write: count increments the cycle after the `host_we` edge.
- `stream_done` rises the cycle after the edge that consumes the final outstanding word.
- `host_ready` falls the cycle after `load_done` is accepted and rises the cycle after `clear`.
- Asynchronous `reset` mid-stream: outputs go to reset values immediately; no further words are delivered.

## Test plan
- **Load and replay:** load weights 0x0001..0x0006 and biases 0x0100..0x0102, `load_done`, `start`, then `weight_en` held 6 cycles and `bias_en` held 3 cycles. Sampled words must equal the load order. `stream_done` rises 1 cycle after the last word. `underrun` stays 0.
- **Replay twice:** after DONE, pulse `start` again. The identical sequence repeats with no reload; counts are unchanged at 6/3.
- **Interleaved and gapped enables:** random single-cycle gaps, and `weight_en` and `bias_en` high together. Every word is delivered exactly once; `wt_data` holds its value across gaps.
- **Underrun:** with 2 weights loaded, 3 `weight_en` cycles. The third edge sets `underrun`, `wt_data` = 0 and `wt_ptr` holds at 2.
- **Overflow and ignored writes:** with `WDEPTH` = 4, write 5 weights. `wt_count` = 4 and `overflow` = 1. A `host_we` during STREAM changes nothing.
- **Reset and clear priority:** assert `reset` mid-stream; all outputs read reset values in the same cycle. Assert `clear` together with `start` in READY: the block goes to IDLE, counts are 0 and `host_ready` = 1.

Source files
------------

// File: rtl/param_streamer.sv
// param_streamer: holds a host-loaded set of weights and biases and replays
// them word by word, in load order, as the engine consumes them. Each data
// output is prefetched so the engine can take one word per cycle with no
// bubbles.
module param_streamer #(
   parameter int DATA_W = 16,
   parameter int WDEPTH = 1024,
   parameter int BDEPTH = 256
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      host_we,
   input  logic                      host_sel,
   input  logic [DATA_W-1:0]         host_data,
   input  logic                      load_done,
   input  logic                      clear,
   input  logic                      start,
   input  logic                      weight_en,
   input  logic                      bias_en,
   output logic [DATA_W-1:0]         wt_data,
   output logic [DATA_W-1:0]         bias_data,
   output logic [$clog2(WDEPTH):0]   wt_count,
   output logic [$clog2(BDEPTH):0]   bias_count,
   output logic                      host_ready,
   output logic                      stream_done,
   output logic                      overflow,
   output logic                      underrun
);

   localparam int WAW = $clog2(WDEPTH);
   localparam int BAW = $clog2(BDEPTH);
   localparam int WCW = WAW + 1;
   localparam int BCW = BAW + 1;

   typedef enum logic [1:0] {IDLE, READY, STREAM, DONE} state_t;

   state_t             state, state_nxt;
   logic [WCW-1:0]     wt_ptr, wt_ptr_nxt, wt_count_nxt;
   logic [BCW-1:0]     b_ptr, b_ptr_nxt, bias_count_nxt;
   logic               overflow_nxt, underrun_nxt;
   logic               wt_we, b_we;
   logic               wt_zero, b_zero;
   logic [DATA_W-1:0]  wt_q, b_q;
   logic [DATA_W-1:0]  wmem [WDEPTH];
   logic [DATA_W-1:0]  bmem [BDEPTH];

   // Next-state, pointer, count and flag computation; the RAM read address is
   // the next pointer so the word appears the cycle after the pointer moves.
   always_comb begin
      state_nxt      = state;
      wt_ptr_nxt     = wt_ptr;
      b_ptr_nxt      = b_ptr;
      wt_count_nxt   = wt_count;
      bias_count_nxt = bias_count;
      overflow_nxt   = overflow;
      underrun_nxt   = underrun;
      wt_we          = 1'b0;
      b_we           = 1'b0;
      if (clear) begin
         state_nxt      = IDLE;
         wt_ptr_nxt     = '0;
         b_ptr_nxt      = '0;
         wt_count_nxt   = '0;
         bias_count_nxt = '0;
         overflow_nxt   = 1'b0;
         underrun_nxt   = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (host_we && !host_sel) begin
                  if (wt_count == WCW'(WDEPTH)) begin
                     overflow_nxt = 1'b1;
                  end else begin
                     wt_we        = 1'b1;
                     wt_count_nxt = wt_count + WCW'(1);
                  end
               end
               if (host_we && host_sel) begin
                  if (bias_count == BCW'(BDEPTH)) begin
                     overflow_nxt = 1'b1;
                  end else begin
                     b_we           = 1'b1;
                     bias_count_nxt = bias_count + BCW'(1);
                  end
               end
               if (load_done && (wt_count != '0)) begin
                  state_nxt = READY;
               end
            end
            READY: begin
               if (start) begin
                  state_nxt  = STREAM;
                  wt_ptr_nxt = '0;
                  b_ptr_nxt  = '0;
               end
            end
            default: begin
               if (start) begin
                  state_nxt  = STREAM;
                  wt_ptr_nxt = '0;
                  b_ptr_nxt  = '0;
               end else begin
                  if (weight_en) begin
                     if (wt_ptr == wt_count) underrun_nxt = 1'b1;
                     else                    wt_ptr_nxt   = wt_ptr + WCW'(1);
                  end
                  if (bias_en) begin
                     if (b_ptr == bias_count) underrun_nxt = 1'b1;
                     else                     b_ptr_nxt    = b_ptr + BCW'(1);
                  end
                  if ((state == STREAM) && (wt_ptr_nxt == wt_count) &&
                      (b_ptr_nxt == bias_count)) begin
                     state_nxt = DONE;
                  end
               end
            end
         endcase
      end
   end

   // Control state, pointers, counts, sticky flags and registered status.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         wt_ptr      <= '0;
         b_ptr       <= '0;
         wt_count    <= '0;
         bias_count  <= '0;
         overflow    <= 1'b0;
         underrun    <= 1'b0;
         host_ready  <= 1'b1;
         stream_done <= 1'b0;
         wt_zero     <= 1'b1;
         b_zero      <= 1'b1;
      end else begin
         state       <= state_nxt;
         wt_ptr      <= wt_ptr_nxt;
         b_ptr       <= b_ptr_nxt;
         wt_count    <= wt_count_nxt;
         bias_count  <= bias_count_nxt;
         overflow    <= overflow_nxt;
         underrun    <= underrun_nxt;
         host_ready  <= (state_nxt == IDLE);
         stream_done <= (state_nxt == DONE);
         wt_zero     <= (wt_ptr_nxt == wt_count_nxt);
         b_zero      <= (b_ptr_nxt == bias_count_nxt);
      end
   end

   // Weight RAM: one write port at the fill count, one synchronous read port.
   always_ff @(posedge clk) begin
      if (wt_we) wmem[wt_count[WAW-1:0]] <= host_data;
      wt_q <= wmem[wt_ptr_nxt[WAW-1:0]];
   end

   // Bias RAM: same organisation as the weight RAM.
   always_ff @(posedge clk) begin
      if (b_we) bmem[bias_count[BAW-1:0]] <= host_data;
      b_q <= bmem[b_ptr_nxt[BAW-1:0]];
   end

   // A pointer sitting at its count shows zero instead of stale RAM data;
   // the zero flags reset high so the outputs clear the instant reset rises.
   assign wt_data   = wt_zero ? '0 : wt_q;
   assign bias_data = b_zero  ? '0 : b_q;

endmodule

// File: tb/tb_param_streamer.sv
// tb_param_streamer: table-driven checks of load, replay, gapped/interleaved
// consumption and clear, plus hand-written underrun, clear-vs-start,
// overflow/ignored-write and asynchronous-reset sequences.
module tb_param_streamer;

   logic        clk = 1'b0;
   logic        reset;
   logic        host_we, host_sel, load_done, clear, start, weight_en, bias_en;
   logic [15:0] host_data;

   logic [15:0] wt_data, bias_data;
   logic [10:0] wt_count;
   logic [8:0]  bias_count;
   logic        host_ready, stream_done, overflow, underrun;

   logic [15:0] s_wt_data, s_bias_data;
   logic [2:0]  s_wt_count;
   logic [1:0]  s_bias_count;
   logic        s_host_ready, s_stream_done, s_overflow, s_underrun;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        we, sel;
      logic [15:0] din;
      logic        ld, clr, st, wen, ben;
      logic        chk;
      logic [15:0] ew, eb;
      int          wc, bc;
      logic        rdy, done, ovf, unr;
   } vec_t;

   vec_t tbl[$];

   param_streamer dut (
      .clk(clk), .reset(reset), .host_we(host_we), .host_sel(host_sel),
      .host_data(host_data), .load_done(load_done), .clear(clear), .start(start),
      .weight_en(weight_en), .bias_en(bias_en), .wt_data(wt_data),
      .bias_data(bias_data), .wt_count(wt_count), .bias_count(bias_count),
      .host_ready(host_ready), .stream_done(stream_done), .overflow(overflow),
      .underrun(underrun)
   );

   param_streamer #(.DATA_W(16), .WDEPTH(4), .BDEPTH(2)) dut_small (
      .clk(clk), .reset(reset), .host_we(host_we), .host_sel(host_sel),
      .host_data(host_data), .load_done(load_done), .clear(clear), .start(start),
      .weight_en(weight_en), .bias_en(bias_en), .wt_data(s_wt_data),
      .bias_data(s_bias_data), .wt_count(s_wt_count), .bias_count(s_bias_count),
      .host_ready(s_host_ready), .stream_done(s_stream_done),
      .overflow(s_overflow), .underrun(s_underrun)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   function automatic vec_t v(input logic we, input logic sel, input logic [15:0] din,
                              input logic ld, input logic clr, input logic st,
                              input logic wen, input logic ben, input logic chk,
                              input logic [15:0] ew, input logic [15:0] eb,
                              input int wc, input int bc, input logic rdy,
                              input logic done, input logic ovf, input logic unr);
      vec_t r;
      r.we = we; r.sel = sel; r.din = din; r.ld = ld; r.clr = clr; r.st = st;
      r.wen = wen; r.ben = ben; r.chk = chk; r.ew = ew; r.eb = eb;
      r.wc = wc; r.bc = bc; r.rdy = rdy; r.done = done; r.ovf = ovf; r.unr = unr;
      return r;
   endfunction

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic we, input logic sel, input logic [15:0] din,
                                input logic ld, input logic clr, input logic st,
                                input logic wen, input logic ben);
      host_we = we; host_sel = sel; host_data = din; load_done = ld;
      clear = clr; start = st; weight_en = wen; bias_en = ben;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string nm, input logic chk,
                              input logic [15:0] ew, input logic [15:0] eb,
                              input int wc, input int bc, input logic rdy,
                              input logic done, input logic ovf, input logic unr);
      if (chk) begin
         cmp({nm, ".wt_data"}, 32'(wt_data), 32'(ew));
         cmp({nm, ".bias_data"}, 32'(bias_data), 32'(eb));
      end
      cmp({nm, ".wt_count"}, 32'(wt_count), wc);
      cmp({nm, ".bias_count"}, 32'(bias_count), bc);
      cmp({nm, ".host_ready"}, 32'(host_ready), 32'(rdy));
      cmp({nm, ".stream_done"}, 32'(stream_done), 32'(done));
      cmp({nm, ".overflow"}, 32'(overflow), 32'(ovf));
      cmp({nm, ".underrun"}, 32'(underrun), 32'(unr));
   endtask

   // Watchdog so the run always ends even if the sequence stalls.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main test sequence.
   initial begin
      reset = 1'b1;
      applyStimulus(0, 0, 16'h0, 0, 0, 0, 0, 0);

      // Load 6 weights then 3 biases.
      for (int k = 0; k < 6; k++)
         tbl.push_back(v(1, 0, 16'(k + 1), 0, 0, 0, 0, 0, 0, 0, 0, k + 1, 0, 1, 0, 0, 0));
      for (int k = 0; k < 3; k++)
         tbl.push_back(v(1, 1, 16'h0100 + 16'(k), 0, 0, 0, 0, 0, 0, 0, 0, 6, k + 1, 1, 0, 0, 0));
      tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 1, 16'h1, 16'h100, 6, 3, 0, 0, 0, 0));
      tbl.push_back(v(0, 0, 0, 0, 0, 1, 0, 0, 1, 16'h1, 16'h100, 6, 3, 0, 0, 0, 0));
      // Back-to-back replay: 6 weight edges, biases on the first 3.
      tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 1, 1, 16'h2, 16'h101, 6, 3, 0, 0, 0, 0));
      tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 1, 1, 16'h3, 16'h102, 6, 3, 0, 0, 0, 0));
      tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 1, 1, 16'h4, 16'h0,   6, 3, 0, 0, 0, 0));
      tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 0, 1, 16'h5, 16'h0,   6, 3, 0, 0, 0, 0));
      tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 0, 1, 16'h6, 16'h0,   6, 3, 0, 0, 0, 0));
      tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 0, 1, 16'h0, 16'h0,   6, 3, 0, 1, 0, 0));
      tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0, 16'h0,   6, 3, 0, 1, 0, 0));
      // Second replay without reload, with gaps and simultaneous enables.
      tbl.push_back(v(0, 0, 0, 0, 0, 1, 0, 0, 1, 16'h1, 16'h100, 6, 3, 0, 0, 0, 0));
      tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 1, 1, 16'h2, 16'h101, 6, 3, 0, 0, 0, 0));
      tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h2, 16'h101, 6, 3, 0, 0, 0, 0));
      tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 1, 16'h2, 16'h102, 6, 3, 0, 0, 0, 0));
      tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 0, 1, 16'h3, 16'h102, 6, 3, 0, 0, 0, 0));
      tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h3, 16'h102, 6, 3, 0, 0, 0, 0));
      tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 1, 1, 16'h4, 16'h0,   6, 3, 0, 0, 0, 0));
      tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 0, 1, 16'h5, 16'h0,   6, 3, 0, 0, 0, 0));
      tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h5, 16'h0,   6, 3, 0, 0, 0, 0));
      tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 0, 1, 16'h6, 16'h0,   6, 3, 0, 0, 0, 0));
      tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 0, 1, 16'h0, 16'h0,   6, 3, 0, 1, 0, 0));
      // Consumption in DONE sets underrun; then clear with start wins for clear.
      tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 0, 1, 16'h0, 16'h0,   6, 3, 0, 1, 0, 1));
      tbl.push_back(v(0, 0, 0, 0, 1, 1, 0, 0, 1, 16'h0, 16'h0,   0, 0, 1, 0, 0, 0));

      tick();
      tick();
      checkOutput("reset", 1, 16'h0, 16'h0, 0, 0, 1, 0, 0, 0);
      cmp("reset.s_wt_count", 32'(s_wt_count), 0);
      cmp("reset.s_host_ready", 32'(s_host_ready), 1);
      reset = 1'b0;

      for (int i = 0; i < tbl.size(); i++) begin
         applyStimulus(tbl[i].we, tbl[i].sel, tbl[i].din, tbl[i].ld, tbl[i].clr,
                       tbl[i].st, tbl[i].wen, tbl[i].ben);
         tick();
         checkOutput($sformatf("row%0d", i), tbl[i].chk, tbl[i].ew, tbl[i].eb,
                     tbl[i].wc, tbl[i].bc, tbl[i].rdy, tbl[i].done, tbl[i].ovf, tbl[i].unr);
      end

      // Underrun: 2 weights, no biases, 3 weight edges.
      applyStimulus(1, 0, 16'h00A1, 0, 0, 0, 0, 0); tick();
      applyStimulus(1, 0, 16'h00A2, 0, 0, 0, 0, 0); tick();
      applyStimulus(0, 0, 16'h0, 1, 0, 0, 0, 0); tick();
      applyStimulus(0, 0, 16'h0, 0, 0, 1, 0, 0); tick();
      checkOutput("unr_start", 1, 16'h00A1, 16'h0, 2, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 16'h0, 0, 0, 0, 1, 0); tick();
      checkOutput("unr_w1", 1, 16'h00A2, 16'h0, 2, 0, 0, 0, 0, 0);
      tick();
      checkOutput("unr_w2", 1, 16'h0, 16'h0, 2, 0, 0, 1, 0, 0);
      tick();
      checkOutput("unr_w3", 1, 16'h0, 16'h0, 2, 0, 0, 1, 0, 1);
      cmp("unr_w3.wt_ptr", 32'(dut.wt_ptr), 2);
      applyStimulus(0, 0, 16'h0, 0, 1, 0, 0, 0); tick();
      checkOutput("unr_clear", 1, 16'h0, 16'h0, 0, 0, 1, 0, 0, 0);

      // Clear together with start in READY returns to IDLE.
      applyStimulus(1, 0, 16'h0055, 0, 0, 0, 0, 0); tick();
      applyStimulus(0, 0, 16'h0, 1, 0, 0, 0, 0); tick();
      checkOutput("ready", 1, 16'h0055, 16'h0, 1, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 16'h0, 0, 1, 1, 0, 0); tick();
      checkOutput("clr_start", 1, 16'h0, 16'h0, 0, 0, 1, 0, 0, 0);
      applyStimulus(0, 0, 16'h0, 0, 0, 0, 0, 0); tick();
      checkOutput("clr_start_idle", 0, 16'h0, 16'h0, 0, 0, 1, 0, 0, 0);

      // Overflow on the 4-deep instance; the large instance keeps all 5.
      for (int k = 0; k < 5; k++) begin
         applyStimulus(1, 0, 16'h0011 + 16'(k), 0, 0, 0, 0, 0);
         tick();
         if (k == 3) begin
            cmp("ovf4.s_wt_count", 32'(s_wt_count), 4);
            cmp("ovf4.s_overflow", 32'(s_overflow), 0);
         end
      end
      cmp("ovf5.s_wt_count", 32'(s_wt_count), 4);
      cmp("ovf5.s_overflow", 32'(s_overflow), 1);
      checkOutput("ovf5.main", 0, 16'h0, 16'h0, 5, 0, 1, 0, 0, 0);
      applyStimulus(0, 0, 16'h0, 1, 0, 0, 0, 0); tick();
      applyStimulus(0, 0, 16'h0, 0, 0, 1, 0, 0); tick();
      cmp("ovf_start.s_wt_data", 32'(s_wt_data), 32'h11);
      applyStimulus(1, 0, 16'h00EE, 0, 0, 0, 0, 0); tick();
      cmp("stream_we.s_wt_count", 32'(s_wt_count), 4);
      cmp("stream_we.s_wt_data", 32'(s_wt_data), 32'h11);
      checkOutput("stream_we.main", 1, 16'h0011, 16'h0, 5, 0, 0, 0, 0, 0);

      // Asynchronous reset mid-stream clears outputs without a clock edge.
      applyStimulus(0, 0, 16'h0, 0, 0, 0, 1, 0); tick();
      checkOutput("pre_reset", 1, 16'h0012, 16'h0, 5, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 16'h0, 0, 0, 0, 0, 0);
      #3;
      reset = 1'b1;
      #1;
      checkOutput("async_reset", 1, 16'h0, 16'h0, 0, 0, 1, 0, 0, 0);
      cmp("async_reset.s_wt_data", 32'(s_wt_data), 0);
      cmp("async_reset.s_overflow", 32'(s_overflow), 0);
      cmp("async_reset.s_wt_count", 32'(s_wt_count), 0);
      reset = 1'b0;
      applyStimulus(0, 0, 16'h0, 0, 0, 0, 1, 0); tick();
      checkOutput("post_reset", 1, 16'h0, 16'h0, 0, 0, 1, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
